ibex_hpm_counter_bank: RTL and testbench
========================================

// Module: ibex_hpm_counter_bank
// PURPOSE
//  Parametrised bank of RISC-V hardware performance monitor counters (mhpmcounter3..N,
//  mhpmcounterNh, mhpmevent3..N) for the Ibex CSR unit. Each counter counts cycles in which
//  any of its selected events fire, unless inhibited. Decodes its own CSR addresses and
//  flags overflow per counter. Sits beside the CSR file, which owns mcycle/minstret/mcountinhibit.
// PARAMETERS
//  NumCounters   10  implemented counters, 0..29; counter i maps to mhpmcounter(3+i)
//  CounterWidth  40  counter width in bits, 1..64
//  NumEvents     16  number of event inputs, 1..32; width of each mhpmevent selector
// PORTS
//  clk_i           in   1             clock
//  rst_i           in   1             synchronous reset, active-high
//  csr_we_i        in   1             CSR write strobe
//  csr_addr_i      in   12            CSR address
//  csr_wdata_i     in   32            CSR write data
//  csr_rdata_o     out  32            CSR read data (combinational)
//  csr_hit_o       out  1             csr_addr_i decodes to an implemented HPM CSR
//  inhibit_i       in   NumCounters   mcountinhibit[3+i] from CSR file
//  event_i         in   NumEvents     per-cycle event pulses
//  counter_ovf_o   out  NumCounters   one-cycle overflow pulse per counter
// BEHAVIOUR
//  - Reset: all counters 0, all mhpmevent 0, counter_ovf_o 0. Reset wins over writes/increments.
//  - Decode, i < NumCounters: 0xB03+i lo, 0xB83+i hi, 0x323+i event. Others (incl. i>=NumCounters
//    and 0x320): csr_hit_o=0, csr_rdata_o=0, writes ignored. No illegal-access signalling here.
//  - Read: lo = counter[31:0], zero-extended if CounterWidth<32; hi = counter[CW-1:32] zero-ext,
//    0 when CW<=32; event = mhpmevent[NumEvents-1:0], upper bits read 0 (WARL).
//  - Write lo: counter[min(CW,32)-1:0] <= wdata; upper counter bits unchanged.
//  - Write hi: counter[CW-1:32] <= wdata[CW-33:0]; ignored when CW<=32.
//  - Write event: mhpmevent <= wdata[NumEvents-1:0].
//  - Increment: inc_i = !inhibit_i[i] && |(event_i & mhpmevent_i). Adds exactly 1 per cycle
//    regardless of how many selected events fire. mhpmevent=0 => counter never increments.
//  - Same-cycle write to counter i (lo or hi) and inc_i: write wins, increment dropped.
//    Write to mhpmevent_i takes effect next cycle; current cycle uses old selector.
//  - Wrap: all-ones + 1 -> 0 (modulo 2^CW). counter_ovf_o[i] is registered: high for exactly the
//    cycle after a wrapping increment. CSR writes never raise overflow.
//  - Latency: write or increment visible on csr_rdata_o the following cycle.
//  - NumCounters=0: no state; csr_hit_o=0, csr_rdata_o=0.
// TESTING
//  1. Reset, read 0xB03/0xB83/0x323 -> 0, hit=1; read 0xB03+NumCounters -> hit=0, rdata=0.
//  2. Write 0x323=0x5, pulse event_i[2] 7 cycles, event_i[1] 3 cycles -> 0xB03 reads 7.
//  3. event_i[0] & event_i[2] both high 4 cycles with sel 0x5 -> counter +4, not +8.
//  4. CW=40: write hi=0xFF, lo=0xFFFF_FFFE, event active 2 cycles -> counter 0, ovf pulse
//     exactly 1 cycle after wrap; hi write 0x1FF reads back 0xFF.
//  5. Write lo=0x100 in same cycle as active event -> reads 0x100; inhibit_i[0]=1 freezes count.
//  6. rst_i mid-count with concurrent csr_we_i -> all state 0 next cycle, write discarded.

Source files
------------

// File: rtl/ibex_hpm_counter_bank.sv
// ibex_hpm_counter_bank: mhpmcounter3+/mhpmcounterh/mhpmevent bank; CSR decode (hit, comb rdata, we/wdata), inhibit/event inputs, per-counter overflow pulses
module ibex_hpm_counter_bank #(
  parameter int unsigned NumCounters  = 10,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   csr_we_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [31:0]            csr_wdata_i,
  output logic [31:0]            csr_rdata_o,
  output logic                   csr_hit_o,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic [NumEvents-1:0]   event_i,
  output logic [NumCounters-1:0] counter_ovf_o
);
  if (NumCounters == 0) begin : g_none
    assign csr_rdata_o   = '0;
    assign csr_hit_o     = 1'b0;
    assign counter_ovf_o = '0;
  end else begin : g_bank
    logic [CounterWidth-1:0] cnt [NumCounters];
    logic [CounterWidth-1:0] wlo [NumCounters];
    logic [CounterWidth-1:0] whi [NumCounters];
    logic [NumEvents-1:0]    sel [NumCounters];
    logic [NumCounters-1:0]  we_lo, we_hi, we_ev, inc;
    logic [63:0]             ext;
    always_comb begin
      csr_rdata_o = '0;
      csr_hit_o   = 1'b0;
      we_lo       = '0;
      we_hi       = '0;
      we_ev       = '0;
      inc         = '0;
      ext         = '0;
      for (int i = 0; i < NumCounters; i++) begin
        ext    = 64'(cnt[i]);
        wlo[i] = CounterWidth'({ext[63:32], csr_wdata_i});
        whi[i] = CounterWidth'({csr_wdata_i, ext[31:0]});
        inc[i] = !inhibit_i[i] && |(event_i & sel[i]);
        if (csr_addr_i == 12'(32'hB03 + i)) begin
          csr_hit_o   = 1'b1;
          csr_rdata_o = ext[31:0];
          we_lo[i]    = csr_we_i;
        end
        if (csr_addr_i == 12'(32'hB83 + i)) begin
          csr_hit_o   = 1'b1;
          csr_rdata_o = ext[63:32];
          we_hi[i]    = csr_we_i;
        end
        if (csr_addr_i == 12'(32'h323 + i)) begin
          csr_hit_o   = 1'b1;
          csr_rdata_o = 32'(sel[i]);
          we_ev[i]    = csr_we_i;
        end
      end
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < NumCounters; i++) begin
          cnt[i] <= '0;
          sel[i] <= '0;
        end
        counter_ovf_o <= '0;
      end else begin
        for (int i = 0; i < NumCounters; i++) begin
          cnt[i] <= we_lo[i] ? wlo[i] : we_hi[i] ? whi[i] : cnt[i] + CounterWidth'(inc[i]);
          sel[i] <= we_ev[i] ? csr_wdata_i[NumEvents-1:0] : sel[i];
          counter_ovf_o[i] <= inc[i] && !we_lo[i] && !we_hi[i] && &cnt[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// tb_ibex_hpm_counter_bank: directed self-checking bench for ibex_hpm_counter_bank
module tb_ibex_hpm_counter_bank;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic [9:0]  inhibit_i = '0;
  logic [15:0] event_i = '0;
  logic [9:0]  counter_ovf_o;
  int total = 0;
  int bad = 0;

  ibex_hpm_counter_bank #(.NumCounters(10), .CounterWidth(40), .NumEvents(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
    .inhibit_i(inhibit_i), .event_i(event_i), .counter_ovf_o(counter_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i = 1'b1;
    csr_addr_i = a;
    csr_wdata_i = d;
    tick(1);
    csr_we_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp, input logic hit);
    csr_addr_i = a;
    #1;
    check({tag, "_data"}, 64'(csr_rdata_o), 64'(exp));
    check({tag, "_hit"}, 64'(csr_hit_o), 64'(hit));
  endtask

  initial begin
    tick(2);
    rst_i = 1'b0;
    rd("rst_lo", 12'hB03, 32'h0, 1'b1);
    rd("rst_hi", 12'hB83, 32'h0, 1'b1);
    rd("rst_ev", 12'h323, 32'h0, 1'b1);
    rd("miss_lo", 12'hB0D, 32'h0, 1'b0);
    rd("miss_320", 12'h320, 32'h0, 1'b0);
    check("rst_ovf", 64'(counter_ovf_o), 64'h0);
    wr(12'h323, 32'h5);
    rd("sel_rd", 12'h323, 32'h5, 1'b1);
    wr(12'h324, 32'hFFFF_FFFF);
    rd("sel_warl", 12'h324, 32'h0000_FFFF, 1'b1);
    wr(12'h324, 32'h0);
    wr(12'hB0D, 32'h1234);
    rd("miss_wr", 12'hB0D, 32'h0, 1'b0);
    event_i = 16'h0004;
    tick(7);
    event_i = 16'h0002;
    tick(3);
    event_i = 16'h0000;
    rd("cnt7", 12'hB03, 32'h7, 1'b1);
    event_i = 16'h0005;
    tick(4);
    event_i = 16'h0000;
    rd("cnt11", 12'hB03, 32'hB, 1'b1);
    rd("cnt1_idle", 12'hB04, 32'h0, 1'b1);
    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFE);
    rd("pre_hi", 12'hB83, 32'hFF, 1'b1);
    rd("pre_lo", 12'hB03, 32'hFFFF_FFFE, 1'b1);
    event_i = 16'h0001;
    tick(1);
    check("ovf_before", 64'(counter_ovf_o), 64'h0);
    rd("allones", 12'hB03, 32'hFFFF_FFFF, 1'b1);
    tick(1);
    event_i = 16'h0000;
    check("ovf_pulse", 64'(counter_ovf_o), 64'h1);
    rd("wrap_lo", 12'hB03, 32'h0, 1'b1);
    rd("wrap_hi", 12'hB83, 32'h0, 1'b1);
    tick(1);
    check("ovf_after", 64'(counter_ovf_o), 64'h0);
    wr(12'hB83, 32'h1FF);
    rd("hi_trunc", 12'hB83, 32'hFF, 1'b1);
    check("ovf_on_wr", 64'(counter_ovf_o), 64'h0);
    wr(12'hB83, 32'h0);
    event_i = 16'h0001;
    wr(12'hB03, 32'h100);
    rd("wr_wins", 12'hB03, 32'h100, 1'b1);
    tick(2);
    rd("post_wr", 12'hB03, 32'h102, 1'b1);
    inhibit_i = 10'h001;
    tick(3);
    rd("inhibit", 12'hB03, 32'h102, 1'b1);
    inhibit_i = 10'h000;
    tick(2);
    rd("rst_pre", 12'hB03, 32'h104, 1'b1);
    rst_i = 1'b1;
    wr(12'hB03, 32'h55);
    rst_i = 1'b0;
    event_i = 16'h0000;
    rd("rst_cnt", 12'hB03, 32'h0, 1'b1);
    rd("rst_sel", 12'h323, 32'h0, 1'b1);
    check("rst_ovf2", 64'(counter_ovf_o), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
